uart_tx_scheduler: RTL

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_sched_pkg.sv | 33 +++
 rtl/bin2bcd_seq.sv | 60 ++++++
 rtl/uart_tx_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sched_pkg
//  Description : Shared types and constants for the UART TX scheduler:
//                FSM state encoding, ASCII codes and report message layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } sched_state_t;

    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Status letter, four digits, CR, LF
    localparam int          REPORT_LEN = 7;
    // Largest value representable with four decimal digits
    localparam int unsigned MAX_VALUE  = 9999;

    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
        return ASCII_0 + {4'h0, digit};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential shift-add-3 binary to BCD converter. A start
//                pulse loads the operand; exactly DIGIT_W cycles later the
//                BCD result is final and stays held until the next start.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int DIGIT_W    = 14,
    parameter int BCD_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic [DIGIT_W-1:0]        i_bin,
    output logic                      o_done,
    output logic [4*BCD_DIGITS-1:0]   o_bcd
);

    localparam int CNT_W = $clog2(DIGIT_W + 1);

    logic [DIGIT_W-1:0]      r_bin;
    logic [4*BCD_DIGITS-1:0] r_bcd;
    logic [4*BCD_DIGITS-1:0] w_adj;
    logic [CNT_W-1:0]        r_cnt;

    // Add 3 to every BCD digit of 5 or more ahead of the next shift
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then shift one binary bit into the BCD field per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_bin <= i_bin;
            r_bcd <= '0;
            r_cnt <= CNT_W'(DIGIT_W);
        end else if (r_cnt != '0) begin
            r_bcd <= {w_adj[4*BCD_DIGITS-2:0], r_bin[DIGIT_W-1]};
            r_bin <= {r_bin[DIGIT_W-2:0], 1'b0};
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Done flags the final shift cycle so the caller can leave on that edge
    assign o_done = (r_cnt == CNT_W'(1));
    assign o_bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Shares one UART transmitter between an echo path (single
//                byte) and a status report ("R"/"S", 4 digits, CR, LF).
//                Round-robin arbitration in IDLE; reports are atomic.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int DIGIT_W    = 14,
    parameter int BCD_DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_echo_valid,
    input  logic [7:0]         i_echo_data,
    output logic               o_echo_ready,
    input  logic               i_rpt_req,
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic               i_run_on,
    output logic               o_tx_start,
    output logic [7:0]         o_tx_data,
    input  logic               i_tx_done,
    output logic               o_busy
);

    sched_state_t            r_state;
    sched_state_t            w_next;
    logic                    r_pending;
    logic                    r_rr_echo_first;
    logic                    r_is_report;
    logic                    r_run;
    logic [7:0]              r_echo_byte;
    logic [2:0]              r_idx;
    logic                    w_grant_echo;
    logic                    w_grant_rpt;
    logic                    w_last_byte;
    logic                    w_bcd_done;
    logic [4*BCD_DIGITS-1:0] w_bcd;
    logic [DIGIT_W-1:0]      w_sat;
    logic [3:0]              w_digit;
    logic [7:0]              w_msg_byte;

    // Clamp the counter snapshot to what four decimal digits can show
    always_comb begin
        if ({{(32-DIGIT_W){1'b0}}, i_digit} > MAX_VALUE) begin
            w_sat = DIGIT_W'(MAX_VALUE);
        end else begin
            w_sat = i_digit;
        end
    end

    // The converter captures the snapshot in the report grant cycle
    bin2bcd_seq #(
        .DIGIT_W    (DIGIT_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_grant_rpt),
        .i_bin   (w_sat),
        .o_done  (w_bcd_done),
        .o_bcd   (w_bcd)
    );

    // Round-robin arbitration; a lone requester always wins
    always_comb begin
        w_grant_echo = (r_state == ST_IDLE) && i_echo_valid &&
                       (!r_pending || r_rr_echo_first);
        w_grant_rpt  = (r_state == ST_IDLE) && r_pending &&
                       (!i_echo_valid || !r_rr_echo_first);
        w_last_byte  = (r_idx == 3'(REPORT_LEN - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_rpt) begin
                    w_next = ST_CONV;
                end else if (w_grant_echo) begin
                    w_next = ST_SEND;
                end
            end
            ST_CONV: begin
                if (w_bcd_done) begin
                    w_next = ST_SEND;
                end
            end
            ST_SEND: w_next = ST_WAIT;
            ST_WAIT: begin
                if (i_tx_done) begin
                    w_next = (r_is_report && !w_last_byte) ? ST_SEND : ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Pending flag, arbitration pointer, latched echo byte and report index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending       <= 1'b0;
            r_rr_echo_first <= 1'b1;
            r_is_report     <= 1'b0;
            r_run           <= 1'b0;
            r_echo_byte     <= 8'h00;
            r_idx           <= 3'd0;
        end else begin
            // A request in the grant cycle re-arms pending for one more report
            r_pending <= i_rpt_req | (r_pending & ~w_grant_rpt);
            if (w_grant_echo) begin
                r_echo_byte     <= i_echo_data;
                r_is_report     <= 1'b0;
                r_rr_echo_first <= 1'b0;
            end
            if (w_grant_rpt) begin
                r_is_report     <= 1'b1;
                r_run           <= i_run_on;
                r_idx           <= 3'd0;
                r_rr_echo_first <= 1'b1;
            end
            if (r_state == ST_WAIT && i_tx_done && r_is_report && !w_last_byte) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    // Report byte for the current index; digits go out most significant first
    always_comb begin
        w_digit = 4'h0;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (r_idx == 3'(BCD_DIGITS - d)) begin
                w_digit = w_bcd[4*d +: 4];
            end
        end
        if (r_idx == 3'd0) begin
            w_msg_byte = r_run ? ASCII_R : ASCII_S;
        end else if (r_idx <= 3'(BCD_DIGITS)) begin
            w_msg_byte = digit_to_ascii(w_digit);
        end else if (r_idx == 3'(BCD_DIGITS + 1)) begin
            w_msg_byte = ASCII_CR;
        end else begin
            w_msg_byte = ASCII_LF;
        end
    end

    // FSM outputs; data is held by registers from SEND until done
    always_comb begin
        o_tx_start   = (r_state == ST_SEND);
        o_busy       = (r_state != ST_IDLE);
        o_echo_ready = w_grant_echo;
        o_tx_data    = r_is_report ? w_msg_byte : r_echo_byte;
    end

endmodule
`default_nettype wire
